div_seq_ctrl: RTL and testbench

// - Multi-cycle sequencer for the shared radix-2 restoring divider used by DIV/DIVU in EX.
// - EX holds start_i high and stalls until ready_o; the sequencer latches operands, runs one

---
 rtl/div_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_div_seq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for the shared radix-2 restoring divider
// used by DIV/DIVU in EX. EX holds start_i high and stalls until ready_o; the
// result {remainder, quotient} is held for HI/LO until start_i drops.
//
// Optional feature (macro DIV_EARLY_EXIT_EN): when defined, a divide whose
// dividend magnitude is smaller than the divisor magnitude skips the iteration
// loop and completes straight from IDLE with quotient 0 and the dividend as the
// remainder. When undefined, every non-zero-divisor divide runs DATA_W steps.
//
// Handshake: start_i is a level request. It is sampled only in IDLE and must
// stay high until ready_o is seen. ready_o rises one edge after the result has
// been loaded and stays high with result_o stable while start_i stays high.
// Dropping start_i (or raising annul_i) returns the sequencer to IDLE and clears
// result_o/ready_o on the next edge.
//
// Timing from the edge t that samples start_i in IDLE:
//   early exit   -> ready_o high after edge t+1
//   divide by 0  -> ready_o high after edge t+2
//   normal       -> ready_o high after edge t+DATA_W+1

module div_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  start_i,
    input  logic                  annul_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_BYZERO = 2'b01,
        S_ON     = 2'b10,
        S_END    = 2'b11
    } state_t;

    // Counter value at which the final iteration is performed.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    // Upper half: partial remainder; lower half: remaining dividend bits that
    // are progressively replaced by quotient bits shifted in at bit 0.
    logic [2*DATA_W-1:0]    shreg;
    logic [DATA_W-1:0]      divisor;
    logic                   neg_quot;
    logic                   neg_rem;

    logic [DATA_W-1:0]      abs_a;
    logic [DATA_W-1:0]      abs_b;
    logic                   a_neg;
    logic                   b_neg;
    logic                   early_exit;
    logic [DATA_W:0]        rem_hi;
    logic                   no_borrow;
    logic [DATA_W-1:0]      diff;
    logic [2*DATA_W-1:0]    shreg_step;
    logic [DATA_W-1:0]      quot_raw;
    logic [DATA_W-1:0]      rem_raw;
    logic [DATA_W-1:0]      quot_fix;
    logic [DATA_W-1:0]      rem_fix;

    assign busy_o  = (state != S_IDLE);
    assign state_o = state;

    // Operand magnitudes and the early-exit decision, used only when sampling in IDLE.
    always_comb begin
        a_neg = signed_div_i & opdata1_i[DATA_W-1];
        b_neg = signed_div_i & opdata2_i[DATA_W-1];
        abs_a = a_neg ? -opdata1_i : opdata1_i;
        abs_b = b_neg ? -opdata2_i : opdata2_i;
`ifdef DIV_EARLY_EXIT_EN
        early_exit = (abs_a < abs_b);
`else
        early_exit = 1'b0;
`endif
    end

    // One restoring step: shift the remainder left by one dividend bit, try to
    // subtract the divisor and keep the difference only when it does not borrow.
    always_comb begin
        rem_hi    = shreg[2*DATA_W-1:DATA_W-1];
        no_borrow = (rem_hi >= {1'b0, divisor});
        // The true difference is below the divisor, so it fits in DATA_W bits.
        diff      = rem_hi[DATA_W-1:0] - divisor;
        if (no_borrow) begin
            shreg_step = {diff, shreg[DATA_W-2:0], 1'b1};
        end else begin
            shreg_step = {shreg[2*DATA_W-2:0], 1'b0};
        end
        quot_raw = shreg_step[DATA_W-1:0];
        rem_raw  = shreg_step[2*DATA_W-1:DATA_W];
        // Quotient is negative when operand signs differ; remainder follows the dividend.
        quot_fix = neg_quot ? -quot_raw : quot_raw;
        rem_fix  = neg_rem  ? -rem_raw  : rem_raw;
    end

    // Sequencer FSM: reset beats annul, annul beats every normal transition.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            shreg    <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else if (annul_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_i) begin
                        neg_quot <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        divisor  <= abs_b;
                        cnt      <= '0;
                        if (opdata2_i == '0) begin
                            state <= S_BYZERO;
                        end else if (early_exit) begin
                            // Quotient is zero and the remainder is the dividend as given.
                            state    <= S_END;
                            result_o <= {opdata1_i, {DATA_W{1'b0}}};
                        end else begin
                            state <= S_ON;
                            shreg <= {{DATA_W{1'b0}}, abs_a};
                        end
                    end
                end
                S_BYZERO: begin
                    // No trap from here; EX/CP0 decide what a zero divisor means.
                    state    <= S_END;
                    result_o <= '0;
                end
                S_ON: begin
                    if (!start_i) begin
                        // EX withdrew the request: treat like an annul.
                        state    <= S_IDLE;
                        cnt      <= '0;
                        result_o <= '0;
                    end else begin
                        shreg <= shreg_step;
                        cnt   <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT) begin
                            state    <= S_END;
                            result_o <= {rem_fix, quot_fix};
                        end
                    end
                end
                S_END: begin
                    if (!start_i) begin
                        state    <= S_IDLE;
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Testbench for div_seq_ctrl: table of directed divides, random divides checked
// against an arithmetic model, and hand-written annul/reset/withdraw sequences.
// Expected results are queued when a divide is launched and popped on ready_o.

module tb_div_seq_ctrl;

    localparam int DW = 32;
`ifdef DIV_EARLY_EXIT_EN
    localparam int EE_LAT = 1;
`else
    localparam int EE_LAT = 33;
`endif

    logic            clk;
    logic            rst;
    logic            start;
    logic            annul;
    logic            sgn;
    logic [DW-1:0]   op1;
    logic [DW-1:0]   op2;
    logic [2*DW-1:0] result;
    logic            ready;
    logic            busy;
    logic [1:0]      state;

    int total = 0;
    int bad   = 0;
    logic [2*DW-1:0] exp_q[$];

    typedef struct {
        string           name;
        logic            s;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [2*DW-1:0] res;
        int              lat;
    } vec_t;

    vec_t vecs[$];

    div_seq_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .cpu_clk      (clk),
        .cpu_rst      (rst),
        .start_i      (start),
        .annul_i      (annul),
        .signed_div_i (sgn),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy),
        .state_o      (state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string what, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", what, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic s, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [2*DW-1:0] res, input int lat);
        vec_t v;
        v.name = name;
        v.s    = s;
        v.a    = a;
        v.b    = b;
        v.res  = res;
        v.lat  = lat;
        vecs.push_back(v);
    endtask

    // Reference model: plain 64-bit signed arithmetic, truncating division.
    function automatic logic [2*DW-1:0] model_res(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint na, nb, q, r;
        if (b == '0) return '0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_lat(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint na, nb;
        if (b == '0) return 2;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        if (na < 0) na = -na;
        if (nb < 0) nb = -nb;
        if (na < nb) return EE_LAT;
        return 33;
    endfunction

    // driver: present a request on the falling edge
    task automatic drive(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        op1   = a;
        op2   = b;
    endtask

    task automatic launch(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2*DW-1:0] exp);
        drive(s, a, b);
        exp_q.push_back(exp);
    endtask

    // The next rising edge samples the request; count edges until ready_o.
    task automatic wait_result(input string name, input int exp_lat, input bit scramble);
        int lat;
        bit got;
        logic [2*DW-1:0] e;
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (scramble) begin
                op1 = $urandom;
                op2 = $urandom;
                sgn = 1'($urandom_range(0, 1));
            end
            if (ready) got = 1'b1;
        end
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got %h want queued entry", name, result);
        end else begin
            e = exp_q.pop_front();
            if (!got) begin
                total++;
                bad++;
                $display("FAIL %s timeout: got ready=%0b want ready=1 within 100 edges", name, ready);
            end else begin
                check({name, " latency"}, 64'(lat), 64'(exp_lat));
                check({name, " result"}, result, e);
            end
        end
    endtask

    // Result must stay stable while start is held, then clear once start drops.
    task automatic finish_div(input string name, input logic [2*DW-1:0] exp);
        @(negedge clk);
        check({name, " hold"}, {result[2*DW-1:1], result[0] ^ ~ready}, {exp[2*DW-1:1], exp[0] ^ 1'b0});
        start = 1'b0;
        @(negedge clk);
        check({name, " clear"}, {result, 3'(0)} | {64'(0), ready, busy, 1'b0}, 67'(0));
    endtask

    task automatic check_idle(input string name);
        check({name, " result"}, result, 64'(0));
        check({name, " flags"}, {60'(0), ready, busy, state}, 64'(0));
    endtask

    initial begin
        logic            rs;
        logic [DW-1:0]   ra;
        logic [DW-1:0]   rb;
        logic [2*DW-1:0] re;

        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sgn   = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        add_vec("divu_100_7",     1'b0, 32'd100,      32'd7,        {32'd2, 32'd14},               33);
        add_vec("div_m7_2",       1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33);
        add_vec("div_7_m2",       1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD},  33);
        add_vec("div_5_0",        1'b1, 32'd5,        32'd0,        64'd0,                         2);
        add_vec("div_min_m1",     1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000},         33);
        add_vec("divu_3_10",      1'b0, 32'd3,        32'd10,       {32'd3, 32'd0},                EE_LAT);
        add_vec("divu_max_1",     1'b0, 32'hFFFFFFFF, 32'd1,        {32'd0, 32'hFFFFFFFF},         33);
        add_vec("divu_max_max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'd0, 32'd1},                33);
        add_vec("div_m100_m7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E},  33);
        add_vec("divu_0_0",       1'b0, 32'd0,        32'd0,        64'd0,                         2);
        add_vec("divu_0_5",       1'b0, 32'd0,        32'd5,        64'd0,                         EE_LAT);
        add_vec("div_m3_10",      1'b1, 32'hFFFFFFFD, 32'd10,       {32'hFFFFFFFD, 32'd0},         EE_LAT);
        add_vec("divu_min_max",   1'b0, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'd0},         EE_LAT);
        add_vec("div_min_min",    1'b1, 32'h80000000, 32'h80000000, {32'd0, 32'd1},                33);
        add_vec("divu_max_3",     1'b0, 32'hFFFFFFFF, 32'd3,        {32'd0, 32'h55555555},         33);

        foreach (vecs[i]) begin
            launch(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].res);
            wait_result(vecs[i].name, vecs[i].lat, 1'b0);
            finish_div(vecs[i].name, vecs[i].res);
        end

        for (int i = 0; i < 16; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = $urandom;
                2: begin rb = $urandom; ra = 32'($urandom_range(0, 20)); end
                default: rb = (i % 4 == 3) ? 32'd0 : 32'hFFFFFFFF - 32'($urandom_range(0, 5));
            endcase
            re = model_res(rs, ra, rb);
            launch(rs, ra, rb, re);
            wait_result("random", model_lat(rs, ra, rb), 1'b0);
            finish_div("random", re);
        end

        // operands changing while busy must be ignored
        launch(1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        wait_result("ignore_new", 33, 1'b1);
        finish_div("ignore_new", {32'd2, 32'd14});

        // annul at iteration 10, then an immediate new divide
        drive(1'b0, 32'hFFFFFFFF, 32'd3);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("annul");
        annul = 1'b0;
        op1   = 32'd9;
        op2   = 32'd3;
        exp_q.push_back({32'd0, 32'd3});
        wait_result("annul_restart", 33, 1'b0);
        finish_div("annul_restart", {32'd0, 32'd3});

        // start withdrawn mid-divide
        drive(1'b0, 32'd1000, 32'd9);
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle("withdraw");

        // reset while iterating, start held through reset restarts the divide
        drive(1'b0, 32'd100, 32'd7);
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_on");
        rst = 1'b0;
        exp_q.push_back({32'd2, 32'd14});
        wait_result("rst_on_restart", 33, 1'b0);
        finish_div("rst_on_restart", {32'd2, 32'd14});

        // reset while holding a finished result
        launch(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
        wait_result("rst_end_first", 33, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle("rst_end");
        rst = 1'b0;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        wait_result("rst_end_restart", 33, 1'b0);
        finish_div("rst_end_restart", {32'hFFFFFFFF, 32'hFFFFFFFD});

        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
